sum_accum: RTL and testbench

Downstream stage of the two-bit `adder` block. It consumes a stream of 2-bit sums over a valid/ready handshake and accumulates a fixed number of samples (`COUNT`) into a `WIDTH`-bit total. It then presents that total, with a sticky overflow flag, on an output valid/ready handshake. It gives the adder tests a registered, back-pressured consumer, so synthesis of the adder can be checked through a sequential path.

---
 rtl/sum_accum_pkg.sv | 15 +
 rtl/sum_accum_if.sv | 25 ++
 rtl/sum_accum_ctr.sv | 42 ++++
 rtl/sum_accum.sv | 92 +++++++++
 tb/tb_sum_accum.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the sum_accum block and its sample counter.
package sum_accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int Q_W = 2;

   function automatic int ctr_w(input int count);
      return $clog2(count + 1);
   endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Input sample stream and output result stream of sum_accum, bundled as one interface.
interface sum_accum_if #(
   parameter int WIDTH = 8
);
   import sum_accum_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [Q_W-1:0]   in_q;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_ovf;

   modport master (
      output in_valid, in_q, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_q, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );

endinterface

// File: rtl/sum_accum_ctr.sv
// Counts accepted samples; done_o flags the increment that completes a batch.
module sum_accum_ctr
   import sum_accum_pkg::*;
#(
   parameter int COUNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic done_o
);

   localparam int CW = ctr_w(COUNT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign done_o = inc_i && (cnt_q == CW'(COUNT - 1));

   // next count: clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CW{1'b0}};
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sum_accum.sv
// Accumulates COUNT 2-bit samples into a WIDTH-bit total with a sticky carry flag,
// then holds the result on a valid/ready output until it is taken.
module sum_accum
   import sum_accum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int COUNT = 4
) (
   input logic       clk,
   input logic       reset,
   sum_accum_if.slave bus
);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             accept;
   logic             done;
   logic             clear;
   logic [WIDTH:0]   sum_ext;

   assign bus.in_ready  = (state_q == ACCUM) && !reset;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign clear   = (state_q == HOLD) && bus.out_ready;
   // one extra bit captures the carry out of WIDTH
   assign sum_ext = {1'b0, acc_q} + {{(WIDTH + 1 - Q_W){1'b0}}, bus.in_q};

   sum_accum_ctr #(
      .COUNT (COUNT)
   ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .inc_i   (accept),
      .done_o  (done)
   );

   // next-state and accumulator update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               acc_d = sum_ext[WIDTH-1:0];
               ovf_d = ovf_q | sum_ext[WIDTH];
               if (done) begin
                  state_d = HOLD;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               acc_d   = {WIDTH{1'b0}};
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // state, accumulator and carry registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         acc_q   <= {WIDTH{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum: three instances cover WIDTH=8/COUNT=4, WIDTH=2/COUNT=4, COUNT=1.
module tb_sum_accum;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       in_valid  = 1'b0;
   logic [1:0] in_q      = 2'd0;
   logic       out_ready = 1'b1;
   int         cur       = 0;

   logic       ov;
   logic       ir;
   logic       oo;
   logic [7:0] os;

   typedef struct {
      int sum;
      bit ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_acc, m_cnt, mw, mc;
   bit   m_ovf, m_hold;
   int   n_res = 0;
   int   last_sum;
   bit   last_ovf;

   sum_accum_if #(.WIDTH(8)) if_a ();
   sum_accum_if #(.WIDTH(2)) if_b ();
   sum_accum_if #(.WIDTH(8)) if_c ();

   sum_accum #(.WIDTH(8), .COUNT(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
   sum_accum #(.WIDTH(2), .COUNT(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
   sum_accum #(.WIDTH(8), .COUNT(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

   assign if_a.in_valid  = (cur == 0) ? in_valid : 1'b0;
   assign if_b.in_valid  = (cur == 1) ? in_valid : 1'b0;
   assign if_c.in_valid  = (cur == 2) ? in_valid : 1'b0;
   assign if_a.in_q      = in_q;
   assign if_b.in_q      = in_q;
   assign if_c.in_q      = in_q;
   assign if_a.out_ready = out_ready;
   assign if_b.out_ready = out_ready;
   assign if_c.out_ready = out_ready;

   assign ov = (cur == 0) ? if_a.out_valid : (cur == 1) ? if_b.out_valid : if_c.out_valid;
   assign ir = (cur == 0) ? if_a.in_ready  : (cur == 1) ? if_b.in_ready  : if_c.in_ready;
   assign oo = (cur == 0) ? if_a.out_ovf   : (cur == 1) ? if_b.out_ovf   : if_c.out_ovf;
   assign os = (cur == 0) ? if_a.out_sum   : (cur == 1) ? {6'd0, if_b.out_sum} : if_c.out_sum;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic select(input int sel);
      cur = sel;
      mw  = (sel == 1) ? 2 : 8;
      mc  = (sel == 2) ? 1 : 4;
   endtask

   // Checks outputs against the model before the next edge, then advances the model and clock.
   task automatic step(input string tag);
      int   s;
      exp_t e;
      checks++;
      if (ov !== m_hold) begin
         errors++;
         $display("FAIL %s out_valid got %0b want %0b", tag, ov, m_hold);
      end
      checks++;
      if (ir !== !m_hold) begin
         errors++;
         $display("FAIL %s in_ready got %0b want %0b", tag, ir, !m_hold);
      end
      if (m_hold) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty while result expected", tag);
         end else begin
            if (os !== 8'(sb[0].sum) || oo !== sb[0].ovf) begin
               errors++;
               $display("FAIL %s result got sum=%0d ovf=%0b want sum=%0d ovf=%0b",
                        tag, os, oo, sb[0].sum, sb[0].ovf);
            end
            if (out_ready) begin
               last_sum = sb[0].sum;
               last_ovf = sb[0].ovf;
               void'(sb.pop_front());
               n_res++;
               m_hold = 1'b0;
            end
         end
      end else if (in_valid) begin
         s = m_acc + int'(in_q);
         if (s >= (32'sd1 << mw)) m_ovf = 1'b1;
         m_acc = s % (32'sd1 << mw);
         m_cnt++;
         if (m_cnt == mc) begin
            e.sum = m_acc;
            e.ovf = m_ovf;
            sb.push_back(e);
            m_hold = 1'b1;
            m_acc  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input logic [1:0] q);
      bit accepted = 1'b0;
      in_valid = 1'b1;
      in_q     = q;
      for (int i = 0; i < 20 && !accepted; i++) begin
         bit took;
         took = !m_hold;
         step(tag);
         if (took) accepted = 1'b1;
      end
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL %s sample not accepted within 20 cycles got 0 want 1", tag);
      end
   endtask

   task automatic idle(input string tag, input int n);
      in_valid = 1'b0;
      repeat (n) step(tag);
   endtask

   task automatic do_reset(input string tag);
      in_valid = 1'b1;
      in_q     = 2'd3;
      reset    = 1'b1;
      #1;
      checks++;
      if (ir !== 1'b0) begin
         errors++;
         $display("FAIL %s in_ready during reset got %0b want 0", tag, ir);
      end
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (ov !== 1'b0 || os !== 8'd0 || oo !== 1'b0) begin
         errors++;
         $display("FAIL %s post-reset got valid=%0b sum=%0d ovf=%0b want 0 0 0", tag, ov, os, oo);
      end
   endtask

   task automatic test_reset();
      select(0);
      do_reset("reset");
      checks++;
      if (ir !== 1'b1) begin
         errors++;
         $display("FAIL reset in_ready after release got %0b want 1", ir);
      end
   endtask

   task automatic test_basic();
      int n0;
      select(0);
      do_reset("basic_rst");
      out_ready = 1'b1;
      n0 = n_res;
      send("basic", 2'd0); send("basic", 2'd2); send("basic", 2'd2); send("basic", 2'd2);
      idle("basic", 2);
      checks++;
      if (n_res - n0 !== 1 || last_sum !== 6 || last_ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic results=%0d sum=%0d ovf=%0b want 1 6 0", n_res - n0, last_sum, last_ovf);
      end
   endtask

   task automatic test_overflow();
      select(1);
      do_reset("ovf_rst");
      out_ready = 1'b1;
      send("ovf", 2'd2); send("ovf", 2'd2); send("ovf", 2'd2); send("ovf", 2'd2);
      idle("ovf", 2);
      checks++;
      if (last_sum !== 0 || last_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_first sum=%0d ovf=%0b want 0 1", last_sum, last_ovf);
      end
      send("ovf", 2'd1); send("ovf", 2'd0); send("ovf", 2'd0); send("ovf", 2'd0);
      idle("ovf", 2);
      checks++;
      if (last_sum !== 1 || last_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_cleared sum=%0d ovf=%0b want 1 0", last_sum, last_ovf);
      end
      send("ovf", 2'd3); send("ovf", 2'd1); send("ovf", 2'd0); send("ovf", 2'd1);
      idle("ovf", 2);
      checks++;
      if (last_sum !== 1 || last_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky sum=%0d ovf=%0b want 1 1", last_sum, last_ovf);
      end
   endtask

   task automatic test_backpressure();
      int n0;
      select(0);
      do_reset("bp_rst");
      n0 = n_res;
      out_ready = 1'b0;
      send("bp", 2'd3); send("bp", 2'd3); send("bp", 2'd3); send("bp", 2'd3);
      in_valid = 1'b1;
      in_q     = 2'd2;
      repeat (5) step("bp_hold");
      out_ready = 1'b1;
      in_valid  = 1'b0;
      step("bp_release");
      checks++;
      if (ir !== 1'b1) begin
         errors++;
         $display("FAIL bp in_ready after release got %0b want 1", ir);
      end
      idle("bp", 1);
      checks++;
      if (n_res - n0 !== 1 || last_sum !== 12 || last_ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp results=%0d sum=%0d ovf=%0b want 1 12 0", n_res - n0, last_sum, last_ovf);
      end
   endtask

   task automatic test_gaps();
      int n0;
      select(0);
      do_reset("gap_rst");
      out_ready = 1'b1;
      n0 = n_res;
      send("gap", 2'd2); idle("gap", 2);
      send("gap", 2'd1); idle("gap", 1);
      send("gap", 2'd2); send("gap", 2'd1);
      idle("gap", 3);
      checks++;
      if (n_res - n0 !== 1 || last_sum !== 6) begin
         errors++;
         $display("FAIL gaps results=%0d sum=%0d want 1 6", n_res - n0, last_sum);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      select(0);
      do_reset("mid_rst0");
      out_ready = 1'b1;
      n0 = n_res;
      send("mid", 2'd2); send("mid", 2'd2);
      do_reset("mid_rst");
      send("mid", 2'd1); send("mid", 2'd1); send("mid", 2'd1); send("mid", 2'd1);
      idle("mid", 2);
      checks++;
      if (n_res - n0 !== 1 || last_sum !== 4 || last_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid results=%0d sum=%0d ovf=%0b want 1 4 0", n_res - n0, last_sum, last_ovf);
      end
      n0 = n_res;
      out_ready = 1'b0;
      send("hold_rst", 2'd3); send("hold_rst", 2'd3); send("hold_rst", 2'd3); send("hold_rst", 2'd3);
      in_valid = 1'b0;
      step("hold_rst");
      do_reset("hold_rst");
      out_ready = 1'b1;
      idle("hold_rst", 3);
      checks++;
      if (n_res - n0 !== 0) begin
         errors++;
         $display("FAIL reset_hold results=%0d want 0", n_res - n0);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      select(2);
      do_reset("b2b_rst");
      out_ready = 1'b1;
      n0 = n_res;
      send("b2b", 2'd2);
      checks++;
      if (ov !== 1'b1 || os !== 8'd2) begin
         errors++;
         $display("FAIL b2b first result valid=%0b sum=%0d want 1 2", ov, os);
      end
      send("b2b", 2'd1); send("b2b", 2'd0);
      idle("b2b", 2);
      checks++;
      if (n_res - n0 !== 3 || last_sum !== 0) begin
         errors++;
         $display("FAIL b2b results=%0d last=%0d want 3 0", n_res - n0, last_sum);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
